// File: rtl/dsp_slave_pkg.sv
// Shared definitions for the DSP slave engines.
// Contents:
//   F_DSP_SLAVE_*  bit positions of the fields inside the dsp_input*_reg words
//   SIZE_*         data_size encodings (element width selector)
//   state_t        sequencer states of the element-wise summer
package dsp_slave_pkg;

  // dsp_input0_reg: control word
  localparam int F_DSP_SLAVE_START     = 0;
  localparam int F_DSP_SLAVE_SIZE_LO   = 1;
  localparam int F_DSP_SLAVE_SIZE_HI   = 2;
  localparam int F_DSP_SLAVE_SIGNED    = 3;
  // dsp_input1_reg: one input file number per byte
  localparam int F_DSP_SLAVE_INFILE_W  = 8;
  // dsp_input2_reg: element count, LEN_W bits wide starting here
  localparam int F_DSP_SLAVE_LENGTH_LO = 0;
  // dsp_input3_reg: output file number
  localparam int F_DSP_SLAVE_OUTFILE_LO = 0;
  localparam int F_DSP_SLAVE_OUTFILE_HI = 7;

  localparam logic [1:0] SIZE_8       = 2'b00;
  localparam logic [1:0] SIZE_16      = 2'b01;
  localparam logic [1:0] SIZE_32      = 2'b10;
  localparam logic [1:0] SIZE_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_REQ   = 3'd1,
    ST_READ_WAIT  = 3'd2,
    ST_WRITE_REQ  = 3'd3,
    ST_WRITE_WAIT = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

endpackage

// File: rtl/dsp_elem_fmt.sv
// Element formatter for the DSP summer (combinational).
// Extends an incoming element to accumulator width and reduces the
// accumulator back to a 32-bit result word.
// Optional feature macro: DSP_EQUATION_SATURATE_EN
//   defined   -> result clamps to the selected element range; signed
//                results are sign-extended to 32 bits
//   undefined -> result wraps (low data_size bits, zero-filled above)
// Ports:
//   data_size   in  2      element width select (SIZE_8/16/32)
//   data_signed in  1      sign-extend (1) or zero-extend (0) elements
//   raw         in  32     word read from a file; element is its low bits
//   ext         out ACC_W  extended element
//   acc         in  ACC_W  accumulator value
//   result      out 32     word to be written to the output file
module dsp_elem_fmt
  import dsp_slave_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [1:0]       data_size,
  input  logic             data_signed,
  input  logic [31:0]      raw,
  output logic [ACC_W-1:0] ext,
  input  logic [ACC_W-1:0] acc,
  output logic [31:0]      result
);

  always_comb begin
    ext = '0;
    case (data_size)
      SIZE_8:  ext = {{(ACC_W-8){data_signed & raw[7]}}, raw[7:0]};
      SIZE_16: ext = {{(ACC_W-16){data_signed & raw[15]}}, raw[15:0]};
      default: ext = {{(ACC_W-32){data_signed & raw[31]}}, raw};
    endcase
  end

`ifdef DSP_EQUATION_SATURATE_EN
  logic [ACC_W-1:0] umax;
  logic [ACC_W-1:0] smax;
  logic [ACC_W-1:0] smin;
  logic [ACC_W-1:0] sat;

  always_comb begin
    case (data_size)
      SIZE_8: begin
        umax = ACC_W'(32'h0000_00FF);
        smax = ACC_W'(32'h0000_007F);
      end
      SIZE_16: begin
        umax = ACC_W'(32'h0000_FFFF);
        smax = ACC_W'(32'h0000_7FFF);
      end
      default: begin
        umax = ACC_W'(32'hFFFF_FFFF);
        smax = ACC_W'(32'h7FFF_FFFF);
      end
    endcase
    // -(2^(n-1)) is the bitwise complement of 2^(n-1)-1
    smin = ~smax;
    sat  = acc;
    if (data_signed) begin
      if ($signed(acc) > $signed(smax)) begin
        sat = smax;
      end else if ($signed(acc) < $signed(smin)) begin
        sat = smin;
      end
    end else if (acc > umax) begin
      sat = umax;
    end
    // Clamped signed values already carry their sign in the upper bits
    result = sat[31:0];
  end

  logic unused_sat_hi;
  assign unused_sat_hi = ^sat[ACC_W-1:32];
`else
  always_comb begin
    case (data_size)
      SIZE_8:  result = {24'h0, acc[7:0]};
      SIZE_16: result = {16'h0, acc[15:0]};
      default: result = acc[31:0];
    endcase
  end

  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:32];
`endif

endmodule

// File: rtl/dsp_equation_sum_n.sv
// Multi-operand element-wise summer behind the DSP slave registers.
// For each element k < LENGTH: reads element k of NUM_INPUTS input files,
// sums them, writes the sum to the output file, then raises interrupt.
// Optional feature macro: DSP_EQUATION_SATURATE_EN (saturating results,
// handled in dsp_elem_fmt).
// Ports:
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   dsp_input0_reg        start, data_size, data_signed
//   dsp_input1_reg        input file numbers, byte i = operand i
//   dsp_input2_reg        LENGTH (element count)
//   dsp_input3_reg        output file number
//   file_read_data        read data, sampled when a read completes
//   file_active           file port busy with the current request
//   file_num              file selected for the current request
//   file_read/file_write  one-cycle request pulses
//   file_write_data       write data, stable through the write wait
//   busy                  running (not IDLE/DONE)
//   elem_count            elements completed
//   interrupt, error      completion flag, invalid configuration
module dsp_equation_sum_n
  import dsp_slave_pkg::*;
#(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int NUM_INPUTS = 4,
  parameter int ACC_W      = 40,
  parameter int LEN_W      = 16,
  parameter int DEBUG      = 0   // simulation tracing only; no hardware effect
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [dw-1:0]    dsp_input0_reg,
  input  logic [dw-1:0]    dsp_input1_reg,
  input  logic [dw-1:0]    dsp_input2_reg,
  input  logic [dw-1:0]    dsp_input3_reg,
  input  logic [31:0]      file_read_data,
  input  logic             file_active,
  output logic [7:0]       file_num,
  output logic             file_read,
  output logic             file_write,
  output logic [31:0]      file_write_data,
  output logic             busy,
  output logic [LEN_W-1:0] elem_count,
  output logic             interrupt,
  output logic             error
);

  state_t           state_reg, state_next;
  logic             start_reg;
  logic [1:0]       size_reg;
  logic             signed_reg;
  logic [3:0][7:0]  infile_reg;
  logic [7:0]       outfile_reg;
  logic [LEN_W-1:0] len_reg;
  logic [1:0]       op_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [LEN_W-1:0] count_reg;
  logic             error_reg;
  logic             seen_reg;    // file_active observed high during this wait
  logic             second_reg;  // at least one wait cycle already elapsed

  logic             start_bit;
  logic             start_edge;
  logic [1:0]       size_in;
  logic             signed_in;
  logic [LEN_W-1:0] length_in;
  logic [3:0][7:0]  infile_in;
  logic             complete;
  logic             last_op;
  logic             last_elem;
  logic [ACC_W-1:0] elem_ext;
  logic [31:0]      result;

  assign start_bit  = dsp_input0_reg[F_DSP_SLAVE_START];
  assign start_edge = start_bit & ~start_reg;
  assign size_in    = dsp_input0_reg[F_DSP_SLAVE_SIZE_HI:F_DSP_SLAVE_SIZE_LO];
  assign signed_in  = dsp_input0_reg[F_DSP_SLAVE_SIGNED];
  assign length_in  = dsp_input2_reg[F_DSP_SLAVE_LENGTH_LO +: LEN_W];

  for (genvar gi = 0; gi < 4; gi++) begin : g_infile
    assign infile_in[gi] = dsp_input1_reg[F_DSP_SLAVE_INFILE_W*gi +: F_DSP_SLAVE_INFILE_W];
  end

  logic unused_cfg;
  assign unused_cfg = ^{dsp_input0_reg[dw-1:F_DSP_SLAVE_SIGNED+1],
                        dsp_input2_reg[dw-1:LEN_W],
                        dsp_input3_reg[dw-1:F_DSP_SLAVE_OUTFILE_HI+1]};

  // A wait ends on the first idle port cycle after it was seen busy, or on
  // the second wait cycle if the port never reported busy at all.
  assign complete  = ~file_active & (seen_reg | second_reg);
  assign last_op   = (op_reg == 2'(NUM_INPUTS - 1));
  assign last_elem = ((count_reg + LEN_W'(1)) == len_reg);

  dsp_elem_fmt #(.ACC_W(ACC_W)) u_fmt (
    .data_size   (size_reg),
    .data_signed (signed_reg),
    .raw         (file_read_data),
    .ext         (elem_ext),
    .acc         (acc_reg),
    .result      (result)
  );

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg   <= ST_IDLE;
      start_reg   <= 1'b0;
      size_reg    <= SIZE_8;
      signed_reg  <= 1'b0;
      infile_reg  <= '0;
      outfile_reg <= '0;
      len_reg     <= '0;
      op_reg      <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      error_reg   <= 1'b0;
      seen_reg    <= 1'b0;
      second_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_bit;
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            error_reg   <= (size_in == SIZE_INVALID);
            size_reg    <= size_in;
            signed_reg  <= signed_in;
            infile_reg  <= infile_in;
            outfile_reg <= dsp_input3_reg[F_DSP_SLAVE_OUTFILE_HI:F_DSP_SLAVE_OUTFILE_LO];
            len_reg     <= length_in;
            op_reg      <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
          end
        end
        ST_READ_REQ, ST_WRITE_REQ: begin
          seen_reg   <= 1'b0;
          second_reg <= 1'b0;
        end
        ST_READ_WAIT: begin
          if (complete) begin
            acc_reg <= acc_reg + elem_ext;
            if (!last_op) op_reg <= op_reg + 2'd1;
          end else begin
            seen_reg   <= seen_reg | file_active;
            second_reg <= 1'b1;
          end
        end
        ST_WRITE_WAIT: begin
          if (complete) begin
            count_reg <= count_reg + LEN_W'(1);
            acc_reg   <= '0;
            op_reg    <= '0;
          end else begin
            seen_reg   <= seen_reg | file_active;
            second_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!start_bit) error_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next      = state_reg;
    file_num        = '0;
    file_read       = 1'b0;
    file_write      = 1'b0;
    file_write_data = '0;
    busy            = 1'b1;
    interrupt       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_edge) begin
          if (size_in == SIZE_INVALID || length_in == '0) state_next = ST_DONE;
          else                                              state_next = ST_READ_REQ;
        end
      end
      ST_READ_REQ: begin
        file_num   = infile_reg[op_reg];
        file_read  = 1'b1;
        state_next = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        file_num = infile_reg[op_reg];
        if (complete) state_next = last_op ? ST_WRITE_REQ : ST_READ_REQ;
      end
      ST_WRITE_REQ: begin
        file_num        = outfile_reg;
        file_write_data = result;
        file_write      = 1'b1;
        state_next      = ST_WRITE_WAIT;
      end
      ST_WRITE_WAIT: begin
        file_num        = outfile_reg;
        file_write_data = result;
        if (complete) state_next = last_elem ? ST_DONE : ST_READ_REQ;
      end
      ST_DONE: begin
        busy      = 1'b0;
        interrupt = 1'b1;
        if (!start_bit) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign elem_count = count_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_dsp_equation_sum_n.sv
// Directed testbench for dsp_equation_sum_n with a simple file-port model.
// Expected values follow DSP_EQUATION_SATURATE_EN when it is defined.
module tb_dsp_equation_sum_n;
  import dsp_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in0, in1, in2, in3;
  logic [31:0] file_read_data, file_write_data;
  logic        file_active, file_read, file_write, busy, interrupt, error;
  logic [7:0]  file_num;
  logic [15:0] elem_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_equation_sum_n dut (
    .wb_clk          (clk),
    .wb_rst          (rst),
    .dsp_input0_reg  (in0),
    .dsp_input1_reg  (in1),
    .dsp_input2_reg  (in2),
    .dsp_input3_reg  (in3),
    .file_read_data  (file_read_data),
    .file_active     (file_active),
    .file_num        (file_num),
    .file_read       (file_read),
    .file_write      (file_write),
    .file_write_data (file_write_data),
    .busy            (busy),
    .elem_count      (elem_count),
    .interrupt       (interrupt),
    .error           (error)
  );

  // File port model: busy for 'slow' cycles after each request pulse,
  // read data is the word stored for the requested file.
  logic [31:0] fdata [16];
  int          slow = 1;
  int          act_cnt = 0;
  logic [7:0]  req_file = 8'h0;
  int          n_reads = 0;
  int          pulse_bad = 0;
  logic        prev_read = 1'b0, prev_write = 1'b0;
  logic [7:0]  wr_file_q [$];
  logic [31:0] wr_data_q [$];

  assign file_active    = (act_cnt > 0);
  assign file_read_data = fdata[req_file[3:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_cnt    <= 0;
      prev_read  <= 1'b0;
      prev_write <= 1'b0;
    end else begin
      if (file_read || file_write) begin
        act_cnt  <= slow;
        req_file <= file_num;
      end else if (act_cnt > 0) begin
        act_cnt <= act_cnt - 1;
      end
      if (file_read) n_reads <= n_reads + 1;
      if (file_write) begin
        wr_file_q.push_back(file_num);
        wr_data_q.push_back(file_write_data);
      end
      if ((file_read && prev_read) || (file_write && prev_write) || (file_read && file_write))
        pulse_bad <= pulse_bad + 1;
      prev_read  <= file_read;
      prev_write <= file_write;
    end
  end

`ifdef DSP_EQUATION_SATURATE_EN
  localparam logic [31:0] EXP_U8  = 32'h0000_00FF;
  localparam logic [31:0] EXP_S8  = 32'hFFFF_FF80;
  localparam logic [31:0] EXP_U32 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_U8  = 32'h0000_0000;
  localparam logic [31:0] EXP_S8  = 32'h0000_0000;
  localparam logic [31:0] EXP_U32 = 32'h0000_0005;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_files(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
    fdata[1] = a; fdata[2] = b; fdata[3] = c; fdata[4] = d;
  endtask

  // Raise start, then count clock edges after the start-sampling edge
  // until interrupt is seen (bounded).
  task automatic run(input logic [1:0] size, input logic sgn, input logic [15:0] len,
                     output int cyc);
    @(negedge clk);
    in2 = {16'h0, len};
    in0 = {28'h0, sgn, size, 1'b1};
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!interrupt && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic end_run(input string tag, input logic exp_err);
    check({tag, "_irq"}, interrupt, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_err"}, error, exp_err);
    in0[0] = 1'b0;
    @(negedge clk);
    check({tag, "_irq_clr"}, interrupt, 0);
    check({tag, "_err_clr"}, error, 0);
  endtask

  task automatic check_writes(input string tag, input int base, input int n,
                              input logic [31:0] exp);
    check({tag, "_nwr"}, 64'(wr_data_q.size() - base), 64'(n));
    for (int i = 0; i < n && base + i < wr_data_q.size(); i++) begin
      $display("write %s[%0d]: file %0d data 0x%08h", tag, i, wr_file_q[base+i], wr_data_q[base+i]);
      check({tag, "_wdata"}, wr_data_q[base+i], exp);
      check({tag, "_wfile"}, wr_file_q[base+i], 8'd9);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, wb, rb, w;
    for (int i = 0; i < 16; i++) fdata[i] = 32'h0;
    rst = 1'b0;
    in0 = 32'h0; in1 = 32'h0403_0201; in2 = 32'h0; in3 = 32'h0000_0009;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_irq", interrupt, 0);
    check("rst_err", error, 0);
    check("rst_rd", file_read, 0);
    check("rst_wr", file_write, 0);
    check("rst_cnt", elem_count, 0);
    check("rst_fnum", file_num, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Signed 16b, LENGTH=3, {1,2,3,4}: 45 cycles, three writes of 10
    set_files(32'h5555_0001, 32'hAAAA_0002, 32'h0000_0003, 32'hFFFF_0004);
    wb = wr_data_q.size(); rb = n_reads;
    run(SIZE_16, 1'b1, 16'd3, cyc);
    $display("run s16: cycles %0d elem_count %0d", cyc, elem_count);
    check("s16_cycles", cyc, 45);
    check("s16_count", elem_count, 3);
    check("s16_reads", n_reads - rb, 12);
    check_writes("s16", wb, 3, 32'h0000_000A);
    end_run("s16", 1'b0);

    // Unsigned 8b 0xFF+0x01: wraps (or saturates)
    set_files(32'h1234_56FF, 32'h0000_0001, 32'hABCD_EF00, 32'h0000_0000);
    wb = wr_data_q.size();
    run(SIZE_8, 1'b0, 16'd1, cyc);
    $display("run u8: cycles %0d", cyc);
    check("u8_cycles", cyc, 15);
    check_writes("u8", wb, 1, EXP_U8);
    end_run("u8", 1'b0);

    // Signed 8b 4 x 0x80
    set_files(32'h0000_0080, 32'h0000_0080, 32'h0000_0080, 32'h0000_0080);
    wb = wr_data_q.size();
    run(SIZE_8, 1'b1, 16'd2, cyc);
    $display("run s8: cycles %0d", cyc);
    check("s8_count", elem_count, 2);
    check_writes("s8", wb, 2, EXP_S8);
    end_run("s8", 1'b0);

    // Signed 16b mixed signs: -1+5-2+1 = 3
    set_files(32'h0000_FFFF, 32'h0000_0005, 32'h0000_FFFE, 32'h0000_0001);
    wb = wr_data_q.size();
    run(SIZE_16, 1'b1, 16'd1, cyc);
    $display("run s16neg: cycles %0d", cyc);
    check_writes("s16neg", wb, 1, 32'h0000_0003);
    end_run("s16neg", 1'b0);

    // Unsigned 32b carry out of 32 bits
    set_files(32'h8000_0000, 32'h8000_0000, 32'h0000_0005, 32'h0000_0000);
    wb = wr_data_q.size();
    run(SIZE_32, 1'b0, 16'd1, cyc);
    $display("run u32: cycles %0d", cyc);
    check_writes("u32", wb, 1, EXP_U32);
    end_run("u32", 1'b0);

    // data_size=11: error and interrupt right after the start edge, no access
    wb = wr_data_q.size(); rb = n_reads;
    run(SIZE_INVALID, 1'b0, 16'd3, cyc);
    $display("run bad size: cycles %0d error %0b", cyc, error);
    check("bad_cycles", cyc, 0);
    check("bad_reads", n_reads - rb, 0);
    check("bad_writes", 64'(wr_data_q.size() - wb), 0);
    end_run("bad", 1'b1);

    // LENGTH=0: interrupt, no access, no error
    wb = wr_data_q.size(); rb = n_reads;
    run(SIZE_16, 1'b0, 16'd0, cyc);
    $display("run len0: cycles %0d", cyc);
    check("len0_cycles", cyc, 0);
    check("len0_reads", n_reads - rb, 0);
    check("len0_writes", 64'(wr_data_q.size() - wb), 0);
    end_run("len0", 1'b0);

    // Slow port: busy 7 cycles per request -> 9 cycles per access
    slow = 7;
    set_files(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004);
    wb = wr_data_q.size(); rb = n_reads;
    run(SIZE_16, 1'b1, 16'd2, cyc);
    $display("run slow: cycles %0d", cyc);
    check("slow_cycles", cyc, 90);
    check("slow_reads", n_reads - rb, 8);
    check_writes("slow", wb, 2, 32'h0000_000A);
    end_run("slow", 1'b0);

    // Asynchronous reset while waiting on a read
    @(negedge clk);
    in2 = 32'd3;
    in0 = {28'h0, 1'b1, SIZE_16, 1'b1};
    w = 0;
    while (!file_active && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("arst_active", file_active, 1);
    check("arst_pre_busy", busy, 1);
    check("arst_pre_fnum", file_num, 1);
    #2 rst = 1'b1;
    #1;
    $display("async reset: busy %0b file_num %0d", busy, file_num);
    check("arst_busy", busy, 0);
    check("arst_fnum", file_num, 0);
    check("arst_rd", file_read, 0);
    check("arst_wr", file_write, 0);
    check("arst_wdata", file_write_data, 0);
    check("arst_cnt", elem_count, 0);
    check("arst_irq", interrupt, 0);
    check("arst_err", error, 0);
    in0 = 32'h0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    slow = 1;

    // Fresh start after reset
    wb = wr_data_q.size();
    run(SIZE_16, 1'b1, 16'd1, cyc);
    $display("run post-reset: cycles %0d", cyc);
    check("post_cycles", cyc, 15);
    check("post_count", elem_count, 1);
    check_writes("post", wb, 1, 32'h0000_000A);
    end_run("post", 1'b0);

    check("pulse_width", pulse_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
